// File: rtl/mapu_b_row_packer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mapu_b_row_packer : packs a serial element stream into 4x4 row-major    |
// |                     matrices, double-buffered, for the Matrix APU.      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module mapu_b_row_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [ELEM_WIDTH-1:0] i_elem,
  input  logic                  i_last,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_r0,
  output logic [DATA_WIDTH-1:0] o_r1,
  output logic [DATA_WIDTH-1:0] o_r2,
  output logic [DATA_WIDTH-1:0] o_r3,
  output logic                  o_short,
  output logic [1:0]            o_lvl
);

  localparam logic [3:0] c_LAST_IDX = 4'd15;
  localparam logic [1:0] c_FULL     = 2'd2;

  logic [DATA_WIDTH-1:0] r_buf [2][4];
  logic [DATA_WIDTH-1:0] r_row [4];
  logic [3:0]            r_idx;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_lvl;
  logic                  r_vld;
  logic                  r_short;

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_pop;
  logic                  w_rd_ptr_nxt;
  logic [1:0]            w_lvl_nxt;
  logic [DATA_WIDTH-1:0] w_fill [4];
  logic [DATA_WIDTH-1:0] w_row_nxt [4];

  assign o_rdy = i_en && (r_lvl < c_FULL);

  always_comb begin
    w_accept     = i_vld && o_rdy;
    w_commit     = w_accept && (i_last || (r_idx == c_LAST_IDX));
    w_pop        = r_vld && i_rdy;
    w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
    // Fill buffer as it will look after this edge, including zero-padding on an early i_last.
    for (int rr = 0; rr < 4; rr++) begin
      w_fill[rr] = r_buf[r_wr_ptr][rr];
      for (int cc = 0; cc < 4; cc++) begin
        if (w_accept && (4'(rr*4+cc) == r_idx))
          w_fill[rr][cc*ELEM_WIDTH +: ELEM_WIDTH] = i_elem;
        else if (w_commit && (4'(rr*4+cc) > r_idx))
          w_fill[rr][cc*ELEM_WIDTH +: ELEM_WIDTH] = '0;
      end
    end
    case ({w_commit, w_pop})
      2'b10:   w_lvl_nxt = r_lvl + 2'd1;
      2'b01:   w_lvl_nxt = r_lvl - 2'd1;
      default: w_lvl_nxt = r_lvl;
    endcase
    // Bypass the fill buffer so a matrix is visible the cycle after its commit.
    for (int rr = 0; rr < 4; rr++)
      w_row_nxt[rr] = (w_rd_ptr_nxt == r_wr_ptr) ? w_fill[rr] : r_buf[w_rd_ptr_nxt][rr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int rr = 0; rr < 4; rr++)
          r_buf[b][rr] <= '0;
      for (int rr = 0; rr < 4; rr++)
        r_row[rr] <= '0;
      r_idx    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_lvl    <= '0;
      r_vld    <= 1'b0;
      r_short  <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int rr = 0; rr < 4; rr++)
          r_buf[r_wr_ptr][rr] <= w_fill[rr];
        r_idx <= w_commit ? 4'd0 : r_idx + 4'd1;
      end
      for (int rr = 0; rr < 4; rr++)
        r_row[rr] <= w_row_nxt[rr];
      r_wr_ptr <= r_wr_ptr ^ w_commit;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_lvl    <= w_lvl_nxt;
      r_vld    <= (w_lvl_nxt != 2'd0);
      r_short  <= w_commit && (r_idx != c_LAST_IDX);
    end
  end

  assign o_vld   = r_vld;
  assign o_short = r_short;
  assign o_lvl   = r_lvl;
  assign o_r0    = r_row[0];
  assign o_r1    = r_row[1];
  assign o_r2    = r_row[2];
  assign o_r3    = r_row[3];

  a_in_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (i_vld && !o_rdy) |=> (!i_vld || ($stable(i_elem) && $stable(i_last))));
  a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (o_vld && !i_rdy) |=> ($stable(o_r0) && $stable(o_r1) && $stable(o_r2) && $stable(o_r3)));
  a_lvl_max: assert property (@(posedge clk) disable iff (!reset_n) (o_lvl <= c_FULL));

endmodule
`default_nettype wire

// File: tb/tb_mapu_b_row_packer.sv
`default_nettype none
// Directed bench for mapu_b_row_packer: basic pack, backpressure, short matrix,
// simultaneous commit/pop, enable stall and mid-matrix reset.
module tb_mapu_b_row_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_en, i_vld, i_last, i_rdy;
  logic [7:0]  i_elem;
  logic        o_rdy, o_vld, o_short;
  logic [31:0] o_r0, o_r1, o_r2, o_r3;
  logic [1:0]  o_lvl;

  int total = 0;
  int bad   = 0;
  logic [127:0] pop_q [$];

  always #5 clk = ~clk;

  mapu_b_row_packer #(.DATA_WIDTH(32), .ELEM_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_elem(i_elem), .i_last(i_last), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_r0(o_r0), .o_r1(o_r1), .o_r2(o_r2), .o_r3(o_r3),
    .o_short(o_short), .o_lvl(o_lvl)
  );

  always @(posedge clk)
    if (reset_n && o_vld && i_rdy) pop_q.push_back({o_r3, o_r2, o_r1, o_r0});

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mat(input logic [7:0] b);
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[k*8 +: 8] = 8'(b + k);
    return m;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_elem(input logic [7:0] e, input logic last, output int cyc);
    bit acc;
    i_vld = 1'b1; i_elem = e; i_last = last; cyc = 0; acc = 0;
    while (!acc && cyc < 200) begin
      @(negedge clk); acc = o_rdy;
      @(posedge clk); #1;
      cyc++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout got no accept want accept of elem %h", e);
    end
  endtask

  task automatic send_stream(input logic [7:0] base, input int n, input logic last_at_end,
                             output int cyc_sum);
    int c;
    cyc_sum = 0;
    for (int i = 0; i < n; i++) begin
      send_elem(8'(base + i), last_at_end && (i == n-1), c);
      cyc_sum += c;
    end
    i_vld = 1'b0; i_last = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_en = 1'b0; i_vld = 1'b0; i_last = 1'b0; i_rdy = 1'b0; i_elem = 8'h00;
    step(); step();
    total++; if ({o_vld, o_short, o_lvl} !== 4'b0) begin bad++;
      $display("FAIL rst_ctrl got %b want 0000", {o_vld, o_short, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== 128'h0) begin bad++;
      $display("FAIL rst_rows got %h want 0", {o_r3, o_r2, o_r1, o_r0}); end
    reset_n = 1'b1; i_en = 1'b1;
    step();
    total++; if (o_rdy !== 1'b1) begin bad++;
      $display("FAIL rst_rdy got %b want 1", o_rdy); end
  endtask

  task automatic test_basic(input string tag);
    int cyc;
    i_en = 1'b1; i_rdy = 1'b1;
    send_stream(8'h00, 16, 1'b1, cyc);
    total++; if (cyc !== 16) begin bad++;
      $display("FAIL %s_throughput got %0d want 16", tag, cyc); end
    total++; if ({o_vld, o_short, o_lvl} !== 4'b1001) begin bad++;
      $display("FAIL %s_ctrl got %b want 1001", tag, {o_vld, o_short, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin bad++;
      $display("FAIL %s_rows got %h want 0f0e0d0c0b0a09080706050403020100", tag, {o_r3, o_r2, o_r1, o_r0}); end
    step();
    total++; if ({o_vld, o_lvl} !== 3'b000) begin bad++;
      $display("FAIL %s_drain got %b want 000", tag, {o_vld, o_lvl}); end
  endtask

  task automatic test_backpressure();
    int cyc;
    i_rdy = 1'b0; pop_q.delete();
    send_stream(8'h00, 32, 1'b0, cyc);
    total++; if (cyc !== 32) begin bad++;
      $display("FAIL bp_fill_cycles got %0d want 32", cyc); end
    total++; if ({o_rdy, o_vld, o_lvl} !== 4'b0110) begin bad++;
      $display("FAIL bp_full got %b want 0110", {o_rdy, o_vld, o_lvl}); end
    i_vld = 1'b1; i_elem = 8'h20;
    for (int i = 0; i < 5; i++) step();
    total++; if ({o_rdy, o_lvl} !== 3'b010) begin bad++;
      $display("FAIL bp_hold got %b want 010", {o_rdy, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== mat(8'h00)) begin bad++;
      $display("FAIL bp_frozen got %h want %h", {o_r3, o_r2, o_r1, o_r0}, mat(8'h00)); end
    i_rdy = 1'b1;
    send_stream(8'h20, 16, 1'b0, cyc);
    step(); step(); step();
    total++; if (pop_q.size() !== 3) begin bad++;
      $display("FAIL bp_count got %0d want 3", pop_q.size()); end
    for (int m = 0; m < 3; m++) begin
      total++; if (pop_q[m] !== mat(8'(m*16))) begin bad++;
        $display("FAIL bp_order%0d got %h want %h", m, pop_q[m], mat(8'(m*16))); end
    end
  endtask

  task automatic test_short();
    int cyc;
    i_rdy = 1'b1;
    send_stream(8'h11, 6, 1'b1, cyc);
    total++; if ({o_vld, o_short, o_lvl} !== 4'b1101) begin bad++;
      $display("FAIL short_ctrl got %b want 1101", {o_vld, o_short, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== 128'h00000000_00000000_00001615_14131211) begin bad++;
      $display("FAIL short_rows got %h want 00000000000000000000161514131211", {o_r3, o_r2, o_r1, o_r0}); end
    step();
    total++; if ({o_short, o_lvl} !== 3'b000) begin bad++;
      $display("FAIL short_pulse got %b want 000", {o_short, o_lvl}); end
  endtask

  task automatic test_commit_pop();
    int cyc;
    i_rdy = 1'b0; pop_q.delete();
    send_stream(8'h40, 16, 1'b1, cyc);
    send_stream(8'h50, 15, 1'b0, cyc);
    total++; if (o_lvl !== 2'd1) begin bad++;
      $display("FAIL cp_pre_lvl got %0d want 1", o_lvl); end
    i_rdy = 1'b1;
    send_stream(8'h5F, 1, 1'b0, cyc);
    total++; if ({o_vld, o_short, o_lvl} !== 4'b1001) begin bad++;
      $display("FAIL cp_ctrl got %b want 1001", {o_vld, o_short, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== mat(8'h50)) begin bad++;
      $display("FAIL cp_rows got %h want %h", {o_r3, o_r2, o_r1, o_r0}, mat(8'h50)); end
    total++; if (pop_q.size() !== 1 || pop_q[0] !== mat(8'h40)) begin bad++;
      $display("FAIL cp_popped got %0d entries want 1 of %h", pop_q.size(), mat(8'h40)); end
    step();
    total++; if (o_lvl !== 2'd0) begin bad++;
      $display("FAIL cp_drain got %0d want 0", o_lvl); end
  endtask

  task automatic test_enable_stall();
    int cyc;
    i_rdy = 1'b1; pop_q.delete();
    send_stream(8'h60, 5, 1'b0, cyc);
    i_en = 1'b0; i_vld = 1'b1; i_elem = 8'h65;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if ({o_rdy, o_lvl} !== 3'b000) begin bad++;
        $display("FAIL stall_c%0d got %b want 000", i, {o_rdy, o_lvl}); end
    end
    i_en = 1'b1;
    send_stream(8'h65, 11, 1'b1, cyc);
    total++; if ({o_vld, o_short, o_lvl} !== 4'b1001) begin bad++;
      $display("FAIL stall_ctrl got %b want 1001", {o_vld, o_short, o_lvl}); end
    step(); step();
    total++; if (pop_q.size() !== 1 || pop_q[0] !== mat(8'h60)) begin bad++;
      $display("FAIL stall_matrix got %0d entries want 1 of %h", pop_q.size(), mat(8'h60)); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    i_rdy = 1'b1;
    send_stream(8'h70, 7, 1'b0, cyc);
    #2 reset_n = 1'b0;
    #1;
    total++; if ({o_vld, o_short, o_lvl} !== 4'b0) begin bad++;
      $display("FAIL mrst_ctrl got %b want 0000", {o_vld, o_short, o_lvl}); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== 128'h0) begin bad++;
      $display("FAIL mrst_rows got %h want 0", {o_r3, o_r2, o_r1, o_r0}); end
    step(); step();
    reset_n = 1'b1;
    step();
    test_basic("mrst");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_backpressure();
    test_short();
    test_commit_pop();
    test_enable_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mapu_b_row_packer.md
Name: mapu_b_row_packer

Overview:
Upstream feeder for the Matrix APU block's data-plane input.
- Accepts a serial stream of matrix elements, one per handshake.
- Assembles them row-major into 4x4 matrices and presents each complete matrix as four packed row words under a valid/ready handshake that connects directly to the APU's i_vld/o_rdy/i_r0..i_r3.
- A two-entry ping-pong buffer lets assembly of the next matrix overlap with APU backpressure.

Parameters:
DATA_WIDTH, 32, row word width; must equal 4*ELEM_WIDTH.
ELEM_WIDTH, 8, width of one matrix element.

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
i_en  input  1  block enable; 0 stalls element intake
i_vld  input  1  element valid
o_rdy  output  1  element ready
i_elem  input  ELEM_WIDTH  element data
i_last  input  1  marks final element of a matrix (optional on element 15, required for short matrices)
o_vld  output  1  matrix valid (to APU i_vld)
i_rdy  input  1  matrix ready (from APU o_rdy)
o_r0..o_r3  output  DATA_WIDTH each  packed rows 0..3 of head matrix
o_short  output  1  one-cycle pulse: matrix committed early via i_last and zero-padded
o_lvl  output  2  number of committed matrices held (0..2)

Behaviour:
- Reset is asynchronous and active-low, and is honoured mid-operation, discarding any partial matrix. Reset values: o_vld=0, o_short=0, o_lvl=0, o_r0..o_r3=0, element index=0, wr_ptr=rd_ptr=0, both buffers zeroed.
- Element accept: i_vld && o_rdy at posedge.
  - o_rdy = i_en && (o_lvl < 2), combinational.
  - When i_en=0, the element index is held; the output side keeps draining.
- Packing: element index k (0..15) maps to row k/4, bits [(k%4)*ELEM_WIDTH +: ELEM_WIDTH] of buf[wr_ptr]. Column 0 is the LSBs.
- Commit happens on accept of index 15, or on accept with i_last=1 at any index.
  - o_lvl increments, wr_ptr toggles, index returns to 0.
  - For an early i_last at index j<15, all positions >j in the committed buffer are written 0 in the same cycle.
  - o_short=1 for exactly the next cycle.
  - i_last at index 15 is a normal commit with no o_short.
- Output:
  - o_vld = (o_lvl != 0), registered.
  - o_r0..o_r3 = buf[rd_ptr], registered and stable while o_vld && !i_rdy.
  - Pop on o_vld && i_rdy: o_lvl decrements, rd_ptr toggles.
- Latency: a matrix whose 16th element is accepted at cycle N has o_vld=1 and valid rows at cycle N+1.
- Simultaneous commit and pop: o_lvl unchanged, both pointers toggle.
- Full (o_lvl=2): o_rdy=0. The fill buffer is never written while it still holds an unpopped matrix.
- Empty (o_lvl=0): o_vld=0. Rows hold their last value; do not check them.
- Throughput: sustains 1 element/cycle with i_rdy=1 (16 cycles/matrix).
- Assertions:
  - i_elem and i_last stable while i_vld && !o_rdy.
  - o_r* stable while o_vld && !i_rdy.
  - o_lvl never exceeds 2.

Test Plan:
1. Basic pack: reset, i_en=1, i_rdy=1, stream 0x00..0x0F, i_last on 0x0F -> cycle after last accept: o_vld=1, o_r0=0x03020100, o_r1=0x07060504, o_r2=0x0B0A0908, o_r3=0x0F0E0D0C, o_short=0, o_lvl=1, then 0.
2. Backpressure/full: i_rdy=0, offer 48 continuous elements 0x00..0x2F -> o_rdy falls after 32 accepts, o_lvl=2, rows frozen at the 0x00..0x0F matrix. Raise i_rdy -> matrices 0x00.., 0x10.. and 0x20.. emerge in order with no loss.
3. Short matrix: elements 0x11..0x16 with i_last on 0x16 -> o_r0=0x14131211, o_r1=0x00001615, o_r2=0, o_r3=0, o_short pulses 1 cycle.
4. Simultaneous commit and pop: o_lvl=1 and i_rdy=1 in the cycle element 15 of the next matrix is accepted -> o_lvl stays 1, o_vld stays 1, rows update to the new matrix next cycle.
5. Enable stall: i_en=0 after 5 elements, hold i_vld 10 cycles -> o_rdy=0, no accepts. i_en=1, send 11 more -> one correct matrix, no duplicated or dropped elements.
6. Reset mid-matrix: assert reset_n=0 asynchronously after 7 elements -> all outputs 0 immediately. Release, send 0x00..0x0F -> output identical to scenario 1.
